// File: rtl/frog_mem_pkg.sv
// Shared constants and load-extension helpers for the FROG memory subsystem.
package frog_mem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_t;

  // Anything that is not an exact byte or half pattern reads as a full word.
  function automatic access_size_t decode_size(input logic [3:0] byte_en);
    access_size_t sz;
    sz = SZ_WORD;
    if (byte_en == BE_BYTE) begin
      sz = SZ_BYTE;
    end else if (byte_en == BE_HALF) begin
      sz = SZ_HALF;
    end
    return sz;
  endfunction

  function automatic logic [31:0] extend_load(
    input logic [31:0]  raw,
    input access_size_t sz,
    input logic         is_signed
  );
    logic [31:0] res;
    res = raw;
    unique case (sz)
      SZ_BYTE: res = {{24{is_signed & raw[7]}}, raw[7:0]};
      SZ_HALF: res = {{16{is_signed & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/frog_dmem.sv
// Byte-addressed little-endian data memory: lane-masked stores, read-first registered loads.
module frog_dmem
  import frog_mem_pkg::*;
#(
  parameter int unsigned DMEM_SIZE_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  input  logic [3:0]  byte_en,
  input  logic        is_signed,
  output logic [31:0] rd_data
);

  localparam int unsigned AW = (DMEM_SIZE_BYTES > 1) ? $clog2(DMEM_SIZE_BYTES) : 1;

  logic [7:0]    mem [0:DMEM_SIZE_BYTES-1];
  logic [AW-1:0] base;
  logic [AW-1:0] lane_addr [4];
  logic [31:0]   raw_word;

  // Each lane wraps independently, so an access near the top spills into byte 0.
  always_comb begin
    base     = AW'(addr % 32'(DMEM_SIZE_BYTES));
    raw_word = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      lane_addr[i]        = AW'((32'(base) + i) % 32'(DMEM_SIZE_BYTES));
      raw_word[8*i +: 8]  = mem[lane_addr[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[lane_addr[i]] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // raw_word is sampled before the store above lands, giving old data on a store cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= extend_load(raw_word, decode_size(byte_en), is_signed);
    end
  end

endmodule

// File: rtl/frog_imem.sv
// Instruction ROM with registered fetch output; contents are loaded by backdoor only.
module frog_imem
  import frog_mem_pkg::*;
#(
  parameter int unsigned IMEM_SIZE_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ready,
  output logic [31:0] instruction
);

  localparam int unsigned IW = (IMEM_SIZE_WORDS > 1) ? $clog2(IMEM_SIZE_WORDS) : 1;

  logic [31:0]   mem [0:IMEM_SIZE_WORDS-1];
  logic [IW-1:0] word_idx;

  // Byte address to word index; the low two address bits drop out in the shift.
  always_comb begin
    word_idx = IW'((pc >> 2) % 32'(IMEM_SIZE_WORDS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= NOP_INSTR;
    end else if (ready) begin
      instruction <= mem[word_idx];
    end
  end

endmodule

// File: rtl/frog_memory.sv
// FROG memory subsystem: independent instruction fetch and data load/store paths.
module frog_memory
  import frog_mem_pkg::*;
#(
  parameter int unsigned IMEM_SIZE_WORDS = 256,
  parameter int unsigned DMEM_SIZE_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_Q100H,
  input  logic        ready_Q101H,
  output logic [31:0] instruction_Q101H,
  input  logic [31:0] alu_out_Q103H,
  input  logic [31:0] dmem_wr_data_Q103H,
  input  logic        dmem_wr_en_Q103H,
  input  logic [3:0]  dmem_byte_en_Q103H,
  input  logic        dmem_is_signed_Q103H,
  output logic [31:0] dmem_rd_data_Q104H
);

  frog_imem #(
    .IMEM_SIZE_WORDS(IMEM_SIZE_WORDS)
  ) i_mem (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc_Q100H),
    .ready       (ready_Q101H),
    .instruction (instruction_Q101H)
  );

  frog_dmem #(
    .DMEM_SIZE_BYTES(DMEM_SIZE_BYTES)
  ) d_mem (
    .clk       (clk),
    .rst       (rst),
    .addr      (alu_out_Q103H),
    .wr_data   (dmem_wr_data_Q103H),
    .wr_en     (dmem_wr_en_Q103H),
    .byte_en   (dmem_byte_en_Q103H),
    .is_signed (dmem_is_signed_Q103H),
    .rd_data   (dmem_rd_data_Q104H)
  );

endmodule

// File: tb/tb_frog_memory.sv
// Randomized self-checking bench for frog_memory against a byte-array reference model.
module tb_frog_memory;

  localparam int unsigned NW = 256;
  localparam int unsigned NB = 1024;

  logic        clk;
  logic        rst;
  logic [31:0] pc_Q100H;
  logic        ready_Q101H;
  logic [31:0] instruction_Q101H;
  logic [31:0] alu_out_Q103H;
  logic [31:0] dmem_wr_data_Q103H;
  logic        dmem_wr_en_Q103H;
  logic [3:0]  dmem_byte_en_Q103H;
  logic        dmem_is_signed_Q103H;
  logic [31:0] dmem_rd_data_Q104H;

  frog_memory #(
    .IMEM_SIZE_WORDS(NW),
    .DMEM_SIZE_BYTES(NB)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pc_Q100H             (pc_Q100H),
    .ready_Q101H          (ready_Q101H),
    .instruction_Q101H    (instruction_Q101H),
    .alu_out_Q103H        (alu_out_Q103H),
    .dmem_wr_data_Q103H   (dmem_wr_data_Q103H),
    .dmem_wr_en_Q103H     (dmem_wr_en_Q103H),
    .dmem_byte_en_Q103H   (dmem_byte_en_Q103H),
    .dmem_is_signed_Q103H (dmem_is_signed_Q103H),
    .dmem_rd_data_Q104H   (dmem_rd_data_Q104H)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] imem_m [NW];
  logic [7:0]  dmem_m [NB];
  logic [31:0] exp_instr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Little-endian assembly with wrap, then size/sign handling by plain arithmetic.
  function automatic logic [31:0] model_load(input int unsigned a, input logic [3:0] be,
                                             input logic sgn);
    longint v;
    if (be == 4'b0001) begin
      v = longint'(dmem_m[a % NB]);
      if (sgn && v >= 128) v = v - 256;
    end else if (be == 4'b0011) begin
      v = longint'(dmem_m[a % NB]) + 256 * longint'(dmem_m[(a + 1) % NB]);
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      v = 0;
      for (int k = 3; k >= 0; k--) v = v * 256 + longint'(dmem_m[(a + k) % NB]);
    end
    return v[31:0];
  endfunction

  task automatic model_store(input int unsigned a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] s;
    s = d;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) dmem_m[(a + k) % NB] = s[7:0];
      s = s >> 8;
    end
  endtask

  // Predict from the inputs in place before the edge, then compare just after it.
  task automatic cycle(input bit chk_rd);
    logic [31:0] exp_rd;
    int unsigned a;
    a = alu_out_Q103H % NB;
    if (rst) begin
      exp_instr = 32'h0000_0013;
      exp_rd    = '0;
    end else begin
      if (ready_Q101H) exp_instr = imem_m[(pc_Q100H / 4) % NW];
      exp_rd = model_load(a, dmem_byte_en_Q103H, dmem_is_signed_Q103H);
      if (dmem_wr_en_Q103H) model_store(a, dmem_byte_en_Q103H, dmem_wr_data_Q103H);
    end
    @(posedge clk);
    #1;
    check("instr", instruction_Q101H, exp_instr);
    if (chk_rd) check("rdata", dmem_rd_data_Q104H, exp_rd);
  endtask

  task automatic drive_d(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic sgn, input logic [31:0] d);
    alu_out_Q103H        = addr;
    dmem_wr_en_Q103H     = we;
    dmem_byte_en_Q103H   = be;
    dmem_is_signed_Q103H = sgn;
    dmem_wr_data_Q103H   = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] be_r;
    rst         = 1'b1;
    pc_Q100H    = '0;
    ready_Q101H = 1'b0;
    exp_instr   = 32'h0000_0013;
    drive_d(32'h0, 1'b0, 4'b1111, 1'b0, 32'h0);

    for (int i = 0; i < int'(NW); i++) begin
      imem_m[i] = $urandom;
    end
    imem_m[0] = 32'h0050_0093;
    imem_m[1] = 32'h00A0_0113;
    for (int i = 0; i < int'(NW); i++) begin
      dut.i_mem.mem[i] = imem_m[i];
    end

    // Reset state
    cycle(1'b1);
    cycle(1'b1);
    check("rst_instr", instruction_Q101H, 32'h0000_0013);
    check("rst_rdata", dmem_rd_data_Q104H, 32'h0);

    // Fetch word 0 then word 1
    rst = 1'b0;
    ready_Q101H = 1'b1;
    pc_Q100H = 32'h0;
    cycle(1'b0);
    check("fetch0", instruction_Q101H, 32'h0050_0093);
    pc_Q100H = 32'h4;
    cycle(1'b0);
    check("fetch1", instruction_Q101H, 32'h00A0_0113);

    // Stall holds the fetched instruction
    ready_Q101H = 1'b0;
    pc_Q100H = 32'h8;
    cycle(1'b0);
    pc_Q100H = 32'hC;
    cycle(1'b0);
    check("stall_hold", instruction_Q101H, 32'h00A0_0113);

    // Give every data byte a known value
    for (int w = 0; w < int'(NB / 4); w++) begin
      drive_d(32'(w * 4), 1'b1, 4'b1111, 1'b0, $urandom);
      cycle(1'b0);
    end

    drive_d(32'h10, 1'b1, 4'b1111, 1'b0, 32'hDEAD_BEEF);
    cycle(1'b1);
    drive_d(32'h10, 1'b0, 4'b1111, 1'b0, 32'h0);
    cycle(1'b1);
    check("word_load", dmem_rd_data_Q104H, 32'hDEAD_BEEF);

    drive_d(32'h10, 1'b0, 4'b0001, 1'b1, 32'h0);
    cycle(1'b1);
    check("byte_signed", dmem_rd_data_Q104H, 32'hFFFF_FFEF);
    drive_d(32'h10, 1'b0, 4'b0001, 1'b0, 32'h0);
    cycle(1'b1);
    check("byte_unsigned", dmem_rd_data_Q104H, 32'h0000_00EF);
    drive_d(32'h12, 1'b0, 4'b0011, 1'b1, 32'h0);
    cycle(1'b1);
    check("half_signed", dmem_rd_data_Q104H, 32'hFFFF_DEAD);

    drive_d(32'h11, 1'b1, 4'b0001, 1'b0, 32'h0000_0055);
    cycle(1'b1);
    drive_d(32'h10, 1'b0, 4'b1111, 1'b0, 32'h0);
    cycle(1'b1);
    check("byte_store", dmem_rd_data_Q104H, 32'hDEAD_55EF);

    // Store while in reset must not land
    rst = 1'b1;
    drive_d(32'h10, 1'b1, 4'b1111, 1'b0, 32'hFFFF_FFFF);
    cycle(1'b1);
    check("rst_mid_rdata", dmem_rd_data_Q104H, 32'h0);
    rst = 1'b0;
    drive_d(32'h10, 1'b0, 4'b1111, 1'b0, 32'h0);
    cycle(1'b1);
    check("rst_store_blocked", dmem_rd_data_Q104H, 32'hDEAD_55EF);

    // Read-first on a same-address store
    drive_d(32'h20, 1'b1, 4'b1111, 1'b0, 32'h0);
    cycle(1'b1);
    drive_d(32'h20, 1'b1, 4'b1111, 1'b0, 32'h1234_5678);
    cycle(1'b1);
    check("read_first_old", dmem_rd_data_Q104H, 32'h0);
    drive_d(32'h20, 1'b0, 4'b1111, 1'b0, 32'h0);
    cycle(1'b1);
    check("read_first_new", dmem_rd_data_Q104H, 32'h1234_5678);

    // Aliasing on both memories
    drive_d(32'h400, 1'b0, 4'b1111, 1'b0, 32'h0);
    ready_Q101H = 1'b1;
    pc_Q100H = 32'h400;
    cycle(1'b1);
    check("imem_alias", instruction_Q101H, 32'h0050_0093);
    drive_d(32'h3FE, 1'b1, 4'b1111, 1'b0, 32'hA1B2_C3D4);
    cycle(1'b1);
    drive_d(32'h0, 1'b0, 4'b0011, 1'b0, 32'h0);
    cycle(1'b1);
    check("dmem_wrap", dmem_rd_data_Q104H, 32'h0000_A1B2);

    // Random traffic on both paths
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 49) == 0);
      ready_Q101H = $urandom_range(0, 3) != 0;
      pc_Q100H    = $urandom;
      case ($urandom_range(0, 3))
        0:       be_r = 4'b0001;
        1:       be_r = 4'b0011;
        2:       be_r = 4'b1111;
        default: be_r = 4'($urandom);
      endcase
      drive_d($urandom_range(0, 2 * NB - 1), $urandom_range(0, 2) == 0, be_r,
              1'($urandom), $urandom);
      cycle(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
